// File: rtl/zone_climate_ctrl.sv
// Multi-zone heat/cool hysteresis controller with per-zone anti-short-cycle dwell.
// Latency: one edge from inputs to outputs. Backpressure: none; it evaluates every cycle.
module zone_climate_ctrl #(
  parameter int TEMP_W    = 5,
  parameter int N_ZONES   = 2,
  parameter int MIN_DWELL = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [N_ZONES*TEMP_W-1:0]   temperature,
  input  logic [TEMP_W-1:0]           heat_on,
  input  logic [TEMP_W-1:0]           heat_off,
  input  logic [TEMP_W-1:0]           cool_off,
  input  logic [TEMP_W-1:0]           cool_on,
  output logic [N_ZONES-1:0]          heating,
  output logic [N_ZONES-1:0]          cooling,
  output logic [N_ZONES-1:0]          sensor_err,
  output logic                        cfg_err
);

  localparam int CNT_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [CNT_W-1:0]  DWELL_MAX = CNT_W'(MIN_DWELL);
  localparam logic [TEMP_W-1:0] SENTINEL  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2} state_t;

  logic cfg_ok;
  logic cfg_err_q;

  assign cfg_ok = (heat_on < heat_off) && (heat_off <= cool_off) && (cool_off < cool_on);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= !cfg_ok;
  end

  assign cfg_err = cfg_err_q;

  genvar i;
  generate
    for (i = 0; i < N_ZONES; i++) begin : g_zone
      logic [TEMP_W-1:0] t;
      state_t            state_q, state_d, want;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic              force_idle;
      logic              sens_q;

      assign t          = temperature[i*TEMP_W +: TEMP_W];
      assign force_idle = !en || !cfg_ok || (t == SENTINEL);

      always_comb begin
        want = state_q;
        case (state_q)
          IDLE:    if (t <= heat_on) want = HEAT;
                   else if (t >= cool_on) want = COOL;
          HEAT:    if (t >= heat_off) want = IDLE;
          COOL:    if (t <= cool_off) want = IDLE;
          default: want = IDLE;
        endcase

        // A wanted change that arrives early stays pending until the dwell counter saturates.
        if (force_idle) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((want != state_q) && (cnt_q == DWELL_MAX)) begin
          state_d = want;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
          cnt_d   = (cnt_q == DWELL_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= IDLE;
          cnt_q   <= DWELL_MAX;
          sens_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          sens_q  <= (t == SENTINEL);
        end
      end

      assign heating[i]    = (state_q == HEAT);
      assign cooling[i]    = (state_q == COOL);
      assign sensor_err[i] = sens_q;
    end
  endgenerate

endmodule

// File: tb/tb_zone_climate_ctrl.sv
// Scoreboard bench for zone_climate_ctrl: directed scenarios then randomized traffic,
// each checked against a mode/time-in-mode reference model.
module tb_zone_climate_ctrl;
  localparam int TW = 5;
  localparam int NZ = 2;
  localparam int MD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NZ*TW-1:0]  temperature;
  logic [TW-1:0]     heat_on, heat_off, cool_off, cool_on;
  logic [NZ-1:0]     heating, cooling, sensor_err;
  logic              cfg_err;

  always #5 clk = ~clk;

  zone_climate_ctrl #(.TEMP_W(TW), .N_ZONES(NZ), .MIN_DWELL(MD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .temperature(temperature),
    .heat_on(heat_on), .heat_off(heat_off), .cool_off(cool_off), .cool_on(cool_on),
    .heating(heating), .cooling(cooling), .sensor_err(sensor_err), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [NZ-1:0] h;
    logic [NZ-1:0] c;
    logic [NZ-1:0] s;
    logic          e;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: mode 0=idle 1=heat 2=cool, held = edges spent in the current mode since last change/force
  int   mode[NZ];
  int   held[NZ];
  int   tz[NZ];
  bit   en_s;
  int   ho, hf, cf, co;
  bit   release_pending = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NZ; i++) begin
      mode[i] = 0;
      held[i] = MD;
    end
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    bit   ok;
    int   want;
    bit   sent;
    e   = '0;
    ok  = (ho < hf) && (hf <= cf) && (cf < co);
    e.e = !ok;
    for (int i = 0; i < NZ; i++) begin
      sent   = (tz[i] == (1 << TW) - 1);
      e.s[i] = sent;
      if (!en_s || !ok || sent) begin
        mode[i] = 0;
        held[i] = 0;
      end else begin
        if (mode[i] == 0)      want = (tz[i] <= ho) ? 1 : ((tz[i] >= co) ? 2 : 0);
        else if (mode[i] == 1) want = (tz[i] >= hf) ? 0 : 1;
        else                   want = (tz[i] <= cf) ? 0 : 2;
        if (want != mode[i] && held[i] >= MD) begin
          mode[i] = want;
          held[i] = 0;
        end else begin
          held[i]++;
        end
      end
      e.h[i] = (mode[i] == 1);
      e.c[i] = (mode[i] == 2);
    end
    return e;
  endfunction

  task automatic drive_and_push();
    exp_t e;
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 0;
    end
    for (int i = 0; i < NZ; i++) temperature[i*TW +: TW] = tz[i][TW-1:0];
    en       = en_s;
    heat_on  = ho[TW-1:0];
    heat_off = hf[TW-1:0];
    cool_off = cf[TW-1:0];
    cool_on  = co[TW-1:0];
    if (!rst_n) e = '0;
    else        e = model_step();
    q.push_back(e);
  endtask

  task automatic apply();
    @(negedge clk);
    drive_and_push();
  endtask

  task automatic cycles(input int n);
    repeat (n) apply();
  endtask

  task automatic nominal();
    en_s = 1; ho = 18; hf = 20; cf = 20; co = 22;
    tz[0] = 20; tz[1] = 20;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    nominal();
    drive_and_push();
    cycles(1);
    release_pending = 1;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
  task automatic mid_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_heating", int'(heating), 0);
    chk("pulse_cooling", int'(cooling), 0);
    chk("pulse_sensor_err", int'(sensor_err), 0);
    chk("pulse_cfg_err", int'(cfg_err), 0);
    model_reset();
    rst_n = 1'b1;
    #1;
    drive_and_push();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("heating", int'(heating), int'(e.h));
        chk("cooling", int'(cooling), int'(e.c));
        chk("sensor_err", int'(sensor_err), int'(e.s));
        chk("cfg_err", int'(cfg_err), int'(e.e));
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    assert ((heating & cooling) == '0)
    else begin
      errors++;
      $display("FAIL overlap at %0t: heating=%b cooling=%b", $time, heating, cooling);
    end
  end

  initial begin : driver
    int r;
    nominal();
    en = 1'b1; temperature = '0;
    heat_on = 5'd18; heat_off = 5'd20; cool_off = 5'd20; cool_on = 5'd22;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_heating", int'(heating), 0);
    chk("reset_cooling", int'(cooling), 0);
    chk("reset_sensor_err", int'(sensor_err), 0);
    chk("reset_cfg_err", int'(cfg_err), 0);

    // Heat on immediately after release, hold in band, release at heat_off
    do_reset();
    tz[0] = 17; cycles(1);
    tz[0] = 19; cycles(6);
    tz[0] = 20; cycles(3);

    // Heat then hot: leave heat at dwell, enter cool after a second dwell
    do_reset();
    tz[0] = 17; cycles(1);
    tz[0] = 25; cycles(12);

    // Sentinel on zone 1 while cooling
    do_reset();
    tz[1] = 23; cycles(3);
    tz[1] = 31; cycles(2);
    tz[1] = 23; cycles(7);

    // Invalid threshold set forces both zones idle
    do_reset();
    tz[0] = 17; tz[1] = 23; cycles(3);
    hf = 23; cycles(2);
    hf = 20; cycles(7);

    // Disable during early heat, then re-enable
    do_reset();
    tz[0] = 17; cycles(2);
    en_s = 0; cycles(1);
    en_s = 1; cycles(7);

    // Reset pulse while zone 1 cools
    do_reset();
    tz[1] = 23; cycles(3);
    mid_pulse();
    cycles(6);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NZ; i++) begin
        r = $urandom_range(0, 15);
        tz[i] = (r == 0) ? 31 : $urandom_range(14, 26);
      end
      en_s = ($urandom_range(0, 15) != 0);
      hf   = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 24) : 20;
      if ($urandom_range(0, 49) == 0) mid_pulse();
      else                            apply();
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zone_climate_ctrl.md
ZONE_CLIMATE_CTRL -- requirements
Module: zone_climate_ctrl

Interface
REQ-001 SHALL provide parameter TEMP_W, default 5, temperature word width in bits (unsigned).
REQ-002 SHALL provide parameter N_ZONES, default 2, number of independent climate channels.
REQ-003 SHALL provide parameter MIN_DWELL, default 4, anti-short-cycle count; each state held >= MIN_DWELL+1 cycles.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  in  1  global enable; 0 forces every zone to IDLE.
REQ-007 SHALL have port temperature  in  N_ZONES*TEMP_W  zone i reading at bits [i*TEMP_W +: TEMP_W].
REQ-008 SHALL have ports heat_on, heat_off, cool_off, cool_on  in  TEMP_W each  shared runtime thresholds.
REQ-009 SHALL have port heating  out  N_ZONES  bit i high while zone i in HEAT.
REQ-010 SHALL have port cooling  out  N_ZONES  bit i high while zone i in COOL.
REQ-011 SHALL have port sensor_err  out  N_ZONES  bit i high while zone i reads sentinel value.
REQ-012 SHALL have port cfg_err  out  1  threshold set invalid.

Function
REQ-013 Each zone SHALL run its own FSM {IDLE, HEAT, COOL} plus dwell counter; zones never interact except via shared en/cfg_err.
REQ-014 All outputs SHALL be registered; response latency one clock edge after inputs settle.
REQ-015 Config valid iff heat_on < heat_off <= cool_off < cool_on, unsigned compare; cfg_err SHALL register the negation each edge.
REQ-016 Sentinel = all-ones (2^TEMP_W-1); sensor_err[i] SHALL register (temperature_i == sentinel) each edge.
REQ-017 Force condition for zone i = !en or config invalid or sentinel on zone i (evaluated combinationally from current inputs).
REQ-018 Forced zone SHALL go to IDLE on the next edge regardless of dwell, counter cleared to 0.
REQ-019 Dwell counter: cleared to 0 on any state change, else increments, saturating at MIN_DWELL.
REQ-020 Unforced transition SHALL occur only when counter == MIN_DWELL before the edge.
REQ-021 IDLE -> HEAT when t <= heat_on; else IDLE -> COOL when t >= cool_on; heat has priority.
REQ-022 HEAT -> IDLE when t >= heat_off; COOL -> IDLE when t <= cool_off.
REQ-023 Direct HEAT <-> COOL SHALL never occur; heating[i] & cooling[i] SHALL never both be 1.
REQ-024 Condition true while dwell not met SHALL be held pending; transition fires on first edge with dwell met and condition still true.
REQ-025 Counter width SHALL be clog2(MIN_DWELL+1), min 1; MIN_DWELL=0 allows change every edge.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) set all zones IDLE, heating=0, cooling=0, sensor_err=0, cfg_err=0.
REQ-027 Reset SHALL set every dwell counter to MIN_DWELL so first decision after release is not delayed.
REQ-028 Reset asserted mid-HEAT/COOL SHALL drop outputs without waiting for a clock edge.

Verification (TEMP_W=5, N_ZONES=2, MIN_DWELL=4, heat_on=18, heat_off=20, cool_off=20, cool_on=22, en=1)
REQ-029 Bench SHALL cover: after reset release, zone0 t=17 -> heating[0]=1 at edge 1; t=19 held -> stays 1; t=20 after 5 cycles in HEAT -> heating[0]=0 next edge.
REQ-030 Bench SHALL cover: zone0 t=17 at edge 0 then t=25 from edge 1 -> heating[0] falls at edge 5, cooling[0] rises at edge 10, never both high.
REQ-031 Bench SHALL cover: zone1 cooling, t=31 -> next edge cooling[1]=0, sensor_err[1]=1, zone0 unaffected; t=23 -> cooling[1] rises after dwell (edge 5 after sentinel cleared).
REQ-032 Bench SHALL cover: both zones active, heat_off set to 23 -> next edge cfg_err=1, heating=cooling=00; restore 20 -> cfg_err=0 next edge.
REQ-033 Bench SHALL cover: en=0 while zone0 HEAT, dwell counter=1 -> heating[0]=0 next edge; en=1 with t=17 -> HEAT re-entered after dwell met.
REQ-034 Bench SHALL cover: rst_n pulsed low between edges while cooling[1]=1 -> cooling[1]=0 before next edge; assertion heating&cooling==0 every cycle.
